// File: rtl/alu_req_arbiter_if.sv
// rtl/alu_req_arbiter_if.sv - request, ALU and response signal bundle for alu_req_arbiter
//
// Purpose: groups the two request channels, the ALU operand/result bus and the
//          tagged response channel that alu_req_arbiter connects together.
// Modports:
//    master : the arbiter itself (takes requests, drives the ALU, drives responses)
//    slave  : the surroundings (requesters, ALU instance, response consumer)
// Signals:
//    req0_valid/req0_a/req0_b/req0_fun, req0_ready : requester 0 channel
//    req1_valid/req1_a/req1_b/req1_fun, req1_ready : requester 1 channel
//    alu_a/alu_b/alu_fun/alu_en                    : registered operation to the ALU
//    alu_out/alu_out_valid                         : ALU result (2*WIDTH)
//    rsp_valid/rsp_ready/rsp_id/rsp_data/rsp_err   : shared response channel
//    busy                                          : arbiter not in IDLE
interface alu_req_arbiter_if #(
   parameter int WIDTH = 8
);
   logic                 req0_valid;
   logic [WIDTH-1:0]     req0_a;
   logic [WIDTH-1:0]     req0_b;
   logic [3:0]           req0_fun;
   logic                 req0_ready;

   logic                 req1_valid;
   logic [WIDTH-1:0]     req1_a;
   logic [WIDTH-1:0]     req1_b;
   logic [3:0]           req1_fun;
   logic                 req1_ready;

   logic [WIDTH-1:0]     alu_a;
   logic [WIDTH-1:0]     alu_b;
   logic [3:0]           alu_fun;
   logic                 alu_en;
   logic [2*WIDTH-1:0]   alu_out;
   logic                 alu_out_valid;

   logic                 rsp_valid;
   logic                 rsp_ready;
   logic                 rsp_id;
   logic [2*WIDTH-1:0]   rsp_data;
   logic                 rsp_err;

   logic                 busy;

   modport master (
      input  req0_valid, req0_a, req0_b, req0_fun,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_fun,
      output req1_ready,
      output alu_a, alu_b, alu_fun, alu_en,
      input  alu_out, alu_out_valid,
      output rsp_valid, rsp_id, rsp_data, rsp_err,
      input  rsp_ready,
      output busy
   );

   modport slave (
      output req0_valid, req0_a, req0_b, req0_fun,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_fun,
      input  req1_ready,
      input  alu_a, alu_b, alu_fun, alu_en,
      output alu_out, alu_out_valid,
      input  rsp_valid, rsp_id, rsp_data, rsp_err,
      output rsp_ready,
      input  busy
   );
endinterface

// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - round-robin sharing of one registered ALU between two requesters
//
// Purpose: accepts one operation at a time from requester 0 or 1 (round-robin when both
//          are valid), issues it to a 1-cycle-latency ALU, and returns the result on a
//          response channel tagged with the requester ID. A missing ALU result is turned
//          into an error response after 4 cycles of waiting.
// Ports:
//    CLK  : clock, rising edge
//    RST  : asynchronous, active-low reset
//    bus  : alu_req_arbiter_if.master (request channels, ALU bus, response channel, busy)
// Build option:
//    ALU_DIV0_GUARD_EN : when defined, a divide (fun 4'b0011) with B==0 is answered directly
//                        with an all-ones error response instead of being sent to the ALU.
module alu_req_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic              CLK,
   input  logic              RST,
   alu_req_arbiter_if.master bus
);

`ifdef ALU_DIV0_GUARD_EN
   localparam bit DIV0_GUARD = 1'b1;
`else
   localparam bit DIV0_GUARD = 1'b0;
`endif

   localparam logic [3:0] FUN_DIV = 4'b0011;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t               state, state_nxt;
   logic                 rr, rr_nxt;
   logic                 op_id, op_id_nxt;
   logic [1:0]           wait_cnt, wait_cnt_nxt;
   logic [WIDTH-1:0]     alu_a_q, alu_a_nxt;
   logic [WIDTH-1:0]     alu_b_q, alu_b_nxt;
   logic [3:0]           alu_fun_q, alu_fun_nxt;
   logic                 alu_en_q, alu_en_nxt;
   logic                 rsp_valid_q, rsp_valid_nxt;
   logic                 rsp_id_q, rsp_id_nxt;
   logic [2*WIDTH-1:0]   rsp_data_q, rsp_data_nxt;
   logic                 rsp_err_q, rsp_err_nxt;

   logic                 idle;
   logic                 gnt0, gnt1;
   logic                 accept;
   logic [WIDTH-1:0]     sel_a, sel_b;
   logic [3:0]           sel_fun;

   // A grant only exists for a valid requester, so READY never rises with nothing to take.
   assign idle    = (state == IDLE);
   assign gnt0    = bus.req0_valid & (~bus.req1_valid | ~rr);
   assign gnt1    = bus.req1_valid & (~bus.req0_valid |  rr);
   assign accept  = idle & (gnt0 | gnt1);
   assign sel_a   = gnt1 ? bus.req1_a   : bus.req0_a;
   assign sel_b   = gnt1 ? bus.req1_b   : bus.req0_b;
   assign sel_fun = gnt1 ? bus.req1_fun : bus.req0_fun;

   assign bus.req0_ready = idle & gnt0;
   assign bus.req1_ready = idle & gnt1;
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_fun    = alu_fun_q;
   assign bus.alu_en     = alu_en_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.rsp_err    = rsp_err_q;
   assign bus.busy       = ~idle;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state       <= IDLE;
         rr          <= 1'b0;
         op_id       <= 1'b0;
         wait_cnt    <= 2'd0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_fun_q   <= 4'd0;
         alu_en_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state       <= state_nxt;
         rr          <= rr_nxt;
         op_id       <= op_id_nxt;
         wait_cnt    <= wait_cnt_nxt;
         alu_a_q     <= alu_a_nxt;
         alu_b_q     <= alu_b_nxt;
         alu_fun_q   <= alu_fun_nxt;
         alu_en_q    <= alu_en_nxt;
         rsp_valid_q <= rsp_valid_nxt;
         rsp_id_q    <= rsp_id_nxt;
         rsp_data_q  <= rsp_data_nxt;
         rsp_err_q   <= rsp_err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      rr_nxt        = rr;
      op_id_nxt     = op_id;
      wait_cnt_nxt  = wait_cnt;
      alu_a_nxt     = alu_a_q;
      alu_b_nxt     = alu_b_q;
      alu_fun_nxt   = alu_fun_q;
      alu_en_nxt    = 1'b0;          // ALU_EN is a single-cycle pulse covering ISSUE
      rsp_valid_nxt = rsp_valid_q;
      rsp_id_nxt    = rsp_id_q;
      rsp_data_nxt  = rsp_data_q;
      rsp_err_nxt   = rsp_err_q;

      case (state)
         IDLE: begin
            if (accept) begin
               op_id_nxt = gnt1;
               rr_nxt    = ~gnt1;
               if (DIV0_GUARD && (sel_fun == FUN_DIV) && (sel_b == '0)) begin
                  state_nxt     = RESP;
                  rsp_valid_nxt = 1'b1;
                  rsp_id_nxt    = gnt1;
                  rsp_data_nxt  = '1;
                  rsp_err_nxt   = 1'b1;
               end else begin
                  // Operands are loaded at accept so they are already on the bus in ISSUE.
                  state_nxt   = ISSUE;
                  alu_a_nxt   = sel_a;
                  alu_b_nxt   = sel_b;
                  alu_fun_nxt = sel_fun;
                  alu_en_nxt  = 1'b1;
               end
            end
         end
         ISSUE: begin
            state_nxt    = WAIT;
            wait_cnt_nxt = 2'd0;
         end
         WAIT: begin
            if (bus.alu_out_valid) begin
               state_nxt     = RESP;
               rsp_valid_nxt = 1'b1;
               rsp_id_nxt    = op_id;
               rsp_data_nxt  = bus.alu_out;
               rsp_err_nxt   = 1'b0;
            end else if (wait_cnt == 2'd3) begin
               // Fourth consecutive WAIT cycle without a result: give up.
               state_nxt     = RESP;
               rsp_valid_nxt = 1'b1;
               rsp_id_nxt    = op_id;
               rsp_data_nxt  = '0;
               rsp_err_nxt   = 1'b1;
            end else begin
               wait_cnt_nxt = wait_cnt + 2'd1;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_nxt     = IDLE;
               rsp_valid_nxt = 1'b0;
               rsp_err_nxt   = 1'b0;
            end
         end
      endcase
   end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb/tb_alu_req_arbiter.sv - directed self-checking bench for alu_req_arbiter
module tb_alu_req_arbiter;

   logic clk;
   logic rst;
   logic alu_mute;
   int   n_checks;
   int   n_fail;

   alu_req_arbiter_if #(.WIDTH(8)) bus ();

   alu_req_arbiter #(.WIDTH(8)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] f);
      case (f)
         4'b0000: alu_model = {8'd0, a} + {8'd0, b};
         4'b0001: alu_model = {8'd0, a} - {8'd0, b};
         4'b0010: alu_model = {8'd0, a} * {8'd0, b};
         4'b0011: alu_model = (b == 8'd0) ? 16'hDEAD : {8'd0, a / b};
         default: alu_model = 16'd0;
      endcase
   endfunction

   // Registered ALU stand-in: result one cycle after ENABLE, unless muted.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.alu_out_valid <= 1'b0;
         bus.alu_out       <= 16'd0;
      end else if (bus.alu_en && !alu_mute) begin
         bus.alu_out_valid <= 1'b1;
         bus.alu_out       <= alu_model(bus.alu_a, bus.alu_b, bus.alu_fun);
      end else begin
         bus.alu_out_valid <= 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic wait_rsp_valid(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = bus.rsp_valid;
      end
   endtask

   task automatic wait_any_ready(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = bus.req0_ready | bus.req1_ready;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b%b expected 00", bus.req0_ready, bus.req1_ready); end
      n_checks++; if (bus.alu_en !== 1'b0 || bus.alu_a !== 8'd0 || bus.alu_b !== 8'd0 || bus.alu_fun !== 4'd0) begin n_fail++; $display("FAIL reset_alu: got en=%b a=%h b=%h fun=%h expected all 0", bus.alu_en, bus.alu_a, bus.alu_b, bus.alu_fun); end
      n_checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 1'b0 || bus.rsp_data !== 16'd0 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp: got v=%b id=%b d=%h e=%b expected all 0", bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      tick();
      rst = 1'b1;
   endtask

   task automatic test_basic_op();
      tick();
      bus.req0_valid = 1'b1; bus.req0_a = 8'd12; bus.req0_b = 8'd5; bus.req0_fun = 4'b0000;
      bus.rsp_ready = 1'b1;
      @(negedge clk);  // T
      n_checks++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_T: got %b expected 1", bus.req0_ready); end
      tick();
      bus.req0_valid = 1'b0;
      @(negedge clk);  // T+1
      n_checks++; if (bus.alu_en !== 1'b1 || bus.alu_a !== 8'd12 || bus.alu_b !== 8'd5 || bus.alu_fun !== 4'd0) begin n_fail++; $display("FAIL basic_issue: got en=%b a=%0d b=%0d fun=%h expected en=1 a=12 b=5 fun=0", bus.alu_en, bus.alu_a, bus.alu_b, bus.alu_fun); end
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", bus.busy); end
      @(negedge clk);  // T+2
      n_checks++; if (bus.alu_en !== 1'b0 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_wait: got en=%b rsp_valid=%b expected 0 0", bus.alu_en, bus.rsp_valid); end
      @(negedge clk);  // T+3
      n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL basic_rsp_valid: got %b expected 1", bus.rsp_valid); end
      n_checks++; if (bus.rsp_id !== 1'b0 || bus.rsp_data !== 16'd17 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL basic_rsp: got id=%b data=%0d err=%b expected id=0 data=17 err=0", bus.rsp_id, bus.rsp_data, bus.rsp_err); end
      @(negedge clk);  // T+4
      n_checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_done: got rsp_valid=%b busy=%b expected 0 0", bus.rsp_valid, bus.busy); end
   endtask

   task automatic test_round_robin();
      bit seen;
      bit gnt;
      apply_reset();
      bus.rsp_ready = 1'b1;
      bus.req0_valid = 1'b1; bus.req0_a = 8'd15; bus.req0_b = 8'd15; bus.req0_fun = 4'b0010;
      bus.req1_valid = 1'b1; bus.req1_a = 8'd15; bus.req1_b = 8'd15; bus.req1_fun = 4'b0010;
      for (int k = 0; k < 6; k++) begin
         wait_any_ready(seen);
         n_checks++; if (!seen) begin n_fail++; $display("FAIL rr_ready_timeout: op %0d got no READY expected one", k); end
         n_checks++; if (bus.req0_ready & bus.req1_ready) begin n_fail++; $display("FAIL rr_one_hot: op %0d got both READY expected one", k); end
         gnt = bus.req1_ready;
         n_checks++; if (gnt !== k[0]) begin n_fail++; $display("FAIL rr_order: op %0d got grant %0d expected %0d", k, gnt, k[0]); end
         wait_rsp_valid(seen);
         n_checks++; if (!seen) begin n_fail++; $display("FAIL rr_rsp_timeout: op %0d got no RSP_VALID expected 1", k); end
         n_checks++; if (bus.rsp_id !== gnt || bus.rsp_data !== 16'd225 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL rr_rsp: op %0d got id=%b data=%0d err=%b expected id=%0d data=225 err=0", k, bus.rsp_id, bus.rsp_data, bus.rsp_err, gnt); end
      end
      tick();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_backpressure();
      bit seen;
      tick();
      bus.req0_valid = 1'b1; bus.req0_a = 8'd3; bus.req0_b = 8'd4; bus.req0_fun = 4'b0000;
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept0: got %b expected 1", bus.req0_ready); end
      tick();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b1; bus.req1_a = 8'd20; bus.req1_b = 8'd30; bus.req1_fun = 4'b0000;
      wait_rsp_valid(seen);
      n_checks++; if (!seen) begin n_fail++; $display("FAIL bp_rsp_timeout: got no RSP_VALID expected 1"); end
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'd7 || bus.rsp_id !== 1'b0) begin n_fail++; $display("FAIL bp_hold: cycle %0d got v=%b data=%0d id=%b expected v=1 data=7 id=0", i, bus.rsp_valid, bus.rsp_data, bus.rsp_id); end
         n_checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || bus.alu_en !== 1'b0) begin n_fail++; $display("FAIL bp_quiet: cycle %0d got rdy=%b%b en=%b expected 000", i, bus.req0_ready, bus.req1_ready, bus.alu_en); end
      end
      tick();
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      n_checks++; if (bus.rsp_valid !== 1'b1 || bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_handshake: got v=%b rdy1=%b expected v=1 rdy1=0", bus.rsp_valid, bus.req1_ready); end
      @(negedge clk);
      n_checks++; if (bus.req1_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_next_accept: got rdy1=%b v=%b expected rdy1=1 v=0", bus.req1_ready, bus.rsp_valid); end
      tick();
      bus.req1_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.alu_en !== 1'b1 || bus.alu_a !== 8'd20 || bus.alu_b !== 8'd30) begin n_fail++; $display("FAIL bp_issue1: got en=%b a=%0d b=%0d expected en=1 a=20 b=30", bus.alu_en, bus.alu_a, bus.alu_b); end
      wait_rsp_valid(seen);
      n_checks++; if (!seen || bus.rsp_id !== 1'b1 || bus.rsp_data !== 16'd50) begin n_fail++; $display("FAIL bp_rsp1: got seen=%b id=%b data=%0d expected seen=1 id=1 data=50", seen, bus.rsp_id, bus.rsp_data); end
   endtask

   task automatic test_timeout();
      tick();
      alu_mute = 1'b1;
      bus.req0_valid = 1'b1; bus.req0_a = 8'd1; bus.req0_b = 8'd2; bus.req0_fun = 4'b0000;
      bus.rsp_ready = 1'b1;
      @(negedge clk);  // T
      n_checks++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL to_accept: got %b expected 1", bus.req0_ready); end
      tick();
      bus.req0_valid = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (i < 6) begin
            n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL to_early: T+%0d got rsp_valid=%b expected 0", i, bus.rsp_valid); end
         end else begin
            n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'd0 || bus.rsp_err !== 1'b1 || bus.rsp_id !== 1'b0) begin n_fail++; $display("FAIL to_rsp: got v=%b data=%h err=%b id=%b expected v=1 data=0 err=1 id=0", bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.rsp_id); end
         end
      end
      @(negedge clk);
      n_checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL to_clear: got v=%b err=%b expected 0 0", bus.rsp_valid, bus.rsp_err); end
      alu_mute = 1'b0;
   endtask

   task automatic test_reset_mid_op();
      bit seen;
      bit any_rsp;
      tick();
      bus.req0_valid = 1'b1; bus.req0_a = 8'd5; bus.req0_b = 8'd5; bus.req0_fun = 4'b0000;
      @(negedge clk);  // T
      n_checks++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL rst_accept: got %b expected 1", bus.req0_ready); end
      tick();
      bus.req0_valid = 1'b0;
      @(negedge clk);  // T+1
      @(negedge clk);  // T+2
      n_checks++; if (bus.busy !== 1'b1 || bus.alu_a !== 8'd5) begin n_fail++; $display("FAIL rst_pre: got busy=%b a=%0d expected busy=1 a=5", bus.busy, bus.alu_a); end
      rst = 1'b0;
      #1;
      n_checks++; if (bus.busy !== 1'b0 || bus.alu_a !== 8'd0 || bus.alu_b !== 8'd0 || bus.alu_en !== 1'b0 || bus.alu_fun !== 4'd0) begin n_fail++; $display("FAIL rst_async_alu: got busy=%b a=%h b=%h en=%b fun=%h expected all 0", bus.busy, bus.alu_a, bus.alu_b, bus.alu_en, bus.alu_fun); end
      n_checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 16'd0 || bus.rsp_err !== 1'b0 || bus.rsp_id !== 1'b0 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL rst_async_rsp: got v=%b d=%h e=%b id=%b rdy=%b%b expected all 0", bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.rsp_id, bus.req0_ready, bus.req1_ready); end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      any_rsp = 1'b0;
      repeat (4) begin
         @(negedge clk);
         any_rsp = any_rsp | bus.rsp_valid;
      end
      n_checks++; if (any_rsp !== 1'b0) begin n_fail++; $display("FAIL rst_no_rsp: got rsp_valid=1 after reset expected 0"); end
      tick();
      bus.req1_valid = 1'b1; bus.req1_a = 8'd7; bus.req1_b = 8'd6; bus.req1_fun = 4'b0010;
      @(negedge clk);
      n_checks++; if (bus.req1_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req1_ready: got %b expected 1", bus.req1_ready); end
      tick();
      bus.req1_valid = 1'b0;
      wait_rsp_valid(seen);
      n_checks++; if (!seen || bus.rsp_id !== 1'b1 || bus.rsp_data !== 16'd42 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_req1_rsp: got seen=%b id=%b data=%0d err=%b expected seen=1 id=1 data=42 err=0", seen, bus.rsp_id, bus.rsp_data, bus.rsp_err); end
      @(negedge clk);
   endtask

   task automatic test_div0();
      tick();
      bus.req0_valid = 1'b1; bus.req0_a = 8'd9; bus.req0_b = 8'd0; bus.req0_fun = 4'b0011;
      bus.rsp_ready = 1'b1;
      @(negedge clk);  // T
      n_checks++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL div0_accept: got %b expected 1", bus.req0_ready); end
      tick();
      bus.req0_valid = 1'b0;
      @(negedge clk);  // T+1
`ifdef ALU_DIV0_GUARD_EN
      n_checks++; if (bus.alu_en !== 1'b0) begin n_fail++; $display("FAIL div0_no_issue: got alu_en=%b expected 0", bus.alu_en); end
      n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'hFFFF || bus.rsp_err !== 1'b1) begin n_fail++; $display("FAIL div0_guard_rsp: got v=%b data=%h err=%b expected v=1 data=ffff err=1", bus.rsp_valid, bus.rsp_data, bus.rsp_err); end
`else
      n_checks++; if (bus.alu_en !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL div0_issue: got en=%b v=%b expected en=1 v=0", bus.alu_en, bus.rsp_valid); end
      @(negedge clk);  // T+2
      @(negedge clk);  // T+3
      n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'hDEAD || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL div0_fwd_rsp: got v=%b data=%h err=%b expected v=1 data=dead err=0", bus.rsp_valid, bus.rsp_data, bus.rsp_err); end
`endif
      @(negedge clk);
      n_checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL div0_done: got v=%b busy=%b expected 0 0", bus.rsp_valid, bus.busy); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      alu_mute = 1'b0;
      rst      = 1'b0;
      bus.req0_valid = 1'b0; bus.req0_a = 8'd0; bus.req0_b = 8'd0; bus.req0_fun = 4'd0;
      bus.req1_valid = 1'b0; bus.req1_a = 8'd0; bus.req1_b = 8'd0; bus.req1_fun = 4'd0;
      bus.rsp_ready  = 1'b1;
      test_reset();
      test_basic_op();
      test_round_robin();
      test_backpressure();
      test_timeout();
      test_reset_mid_op();
      test_div0();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
